// File: rtl/comparator_cell.sv
// Equality/magnitude comparator: combinational z plus registered eq/gt/lt
// with signed/unsigned ordering and saturating mismatch statistics.
module comparator_cell #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 z,
    input  logic                 signed_mode,
    input  logic                 in_valid,
    input  logic                 clr,
    output logic                 out_valid,
    output logic                 eq_q,
    output logic                 gt_q,
    output logic                 lt_q,
    output logic [CNT_WIDTH-1:0] mismatch_cnt,
    output logic                 mismatch_seen
);

    logic [WIDTH-1:0] sign_flip;
    logic [WIDTH-1:0] x_ord;
    logic [WIDTH-1:0] y_ord;
    logic             eq;
    logic             gt;
    logic             lt;

    assign z = (x == y);

    // Inverting the MSB maps two's complement order onto unsigned order,
    // so a single unsigned comparator serves both modes.
    always_comb begin
        sign_flip            = '0;
        sign_flip[WIDTH-1]   = signed_mode;
        x_ord                = x ^ sign_flip;
        y_ord                = y ^ sign_flip;
        eq                   = (x == y);
        gt                   = (x_ord > y_ord);
        lt                   = (x_ord < y_ord);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            eq_q          <= 1'b0;
            gt_q          <= 1'b0;
            lt_q          <= 1'b0;
            mismatch_cnt  <= '0;
            mismatch_seen <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                eq_q <= eq;
                gt_q <= gt;
                lt_q <= lt;
            end
            // clr wins over a same-cycle mismatch; the sample is dropped
            if (clr) begin
                mismatch_cnt  <= '0;
                mismatch_seen <= 1'b0;
            end else if (in_valid && !eq) begin
                mismatch_seen <= 1'b1;
                if (mismatch_cnt != '1) begin
                    mismatch_cnt <= mismatch_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_comparator_cell.sv
// Scoreboard bench for comparator_cell: a WIDTH=4/CNT_WIDTH=2 instance for
// registered behaviour and a WIDTH=1 instance for the truth table and sign.
module tb_comparator_cell;

    typedef logic [6:0] vec_t; // {out_valid, eq, gt, lt, cnt[1:0], seen}

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] a_x = '0, a_y = '0;
    logic       a_sm = 1'b0, a_valid = 1'b0, a_clr = 1'b0;
    logic       a_z, a_ov, a_eq, a_gt, a_lt, a_seen;
    logic [1:0] a_cnt;

    logic       b_x = 1'b0, b_y = 1'b0;
    logic       b_sm = 1'b0, b_valid = 1'b0, b_clr = 1'b0;
    logic       b_z, b_ov, b_eq, b_gt, b_lt, b_seen;
    logic [7:0] b_cnt;

    int checks = 0;
    int errors = 0;

    vec_t sb[$];

    logic       m_ov, m_eq, m_gt, m_lt, m_seen;
    logic [1:0] m_cnt;

    always #5 clk = ~clk;

    comparator_cell #(.WIDTH(4), .CNT_WIDTH(2)) dut4 (
        .clk(clk), .rst(rst), .x(a_x), .y(a_y), .z(a_z),
        .signed_mode(a_sm), .in_valid(a_valid), .clr(a_clr),
        .out_valid(a_ov), .eq_q(a_eq), .gt_q(a_gt), .lt_q(a_lt),
        .mismatch_cnt(a_cnt), .mismatch_seen(a_seen)
    );

    comparator_cell #(.WIDTH(1), .CNT_WIDTH(8)) dut1 (
        .clk(clk), .rst(rst), .x(b_x), .y(b_y), .z(b_z),
        .signed_mode(b_sm), .in_valid(b_valid), .clr(b_clr),
        .out_valid(b_ov), .eq_q(b_eq), .gt_q(b_gt), .lt_q(b_lt),
        .mismatch_cnt(b_cnt), .mismatch_seen(b_seen)
    );

    function automatic vec_t obs4();
        return {a_ov, a_eq, a_gt, a_lt, a_cnt, a_seen};
    endfunction

    task automatic model_reset();
        m_ov = 0; m_eq = 0; m_gt = 0; m_lt = 0; m_cnt = 0; m_seen = 0;
        sb.delete();
    endtask

    // Applies one sample to dut4, pushes the model's expectation, then
    // advances to just after the capturing edge.
    task automatic drive4(input logic [3:0] x, input logic [3:0] y,
                          input logic sm, input logic valid, input logic clr);
        int sx, sy;
        a_x = x; a_y = y; a_sm = sm; a_valid = valid; a_clr = clr;
        sx = sm ? int'($signed(x)) : int'(x);
        sy = sm ? int'($signed(y)) : int'(y);
        m_ov = valid;
        if (valid) begin
            m_eq = (sx == sy); m_gt = (sx > sy); m_lt = (sx < sy);
        end
        if (clr) begin
            m_cnt = 0; m_seen = 0;
        end else if (valid && x != y) begin
            m_seen = 1;
            if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
        end
        sb.push_back({m_ov, m_eq, m_gt, m_lt, m_cnt, m_seen});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (obs4() !== 7'b0) begin
            errors++;
            $display("FAIL reset_state4: got %b expected %b", obs4(), 7'b0);
        end
        checks++;
        if ({b_ov, b_eq, b_gt, b_lt, b_cnt, b_seen} !== 13'b0) begin
            errors++;
            $display("FAIL reset_state1: got %b expected 0",
                     {b_ov, b_eq, b_gt, b_lt, b_cnt, b_seen});
        end
    endtask

    task automatic test_truth_table();
        logic [3:0] exp_z;
        exp_z = 4'b1001; // index {x,y}: 00->1, 01->0, 10->0, 11->1
        for (int i = 0; i < 4; i++) begin
            b_x = i[1]; b_y = i[0];
            #10;
            checks++;
            if (b_z !== exp_z[i]) begin
                errors++;
                $display("FAIL truth_table x=%0b y=%0b: z=%b expected %b", b_x, b_y, b_z, exp_z[i]);
            end
        end
    endtask

    task automatic test_unsigned();
        vec_t e;
        drive4(4'd9, 4'd3, 0, 1, 0);
        e = sb.pop_front();
        checks++;
        if (obs4() !== e || e[6:3] !== 4'b1010) begin
            errors++;
            $display("FAIL unsigned_9_3: got %b expected %b", obs4(), e);
        end
        drive4(4'd0, 4'd0, 0, 0, 0);
        e = sb.pop_front();
        checks++;
        if (obs4() !== e || e[6:3] !== 4'b0010) begin
            errors++;
            $display("FAIL idle_hold: got %b expected %b", obs4(), e);
        end
    endtask

    task automatic test_signed();
        vec_t e;
        drive4(4'hF, 4'h1, 1, 1, 0);
        e = sb.pop_front();
        checks++;
        if (obs4() !== e || a_lt !== 1'b1) begin
            errors++;
            $display("FAIL signed_F_1: got %b expected %b", obs4(), e);
        end
        drive4(4'hF, 4'h1, 0, 1, 0);
        e = sb.pop_front();
        checks++;
        if (obs4() !== e || a_gt !== 1'b1) begin
            errors++;
            $display("FAIL unsigned_F_1: got %b expected %b", obs4(), e);
        end
        b_x = 1; b_y = 0; b_sm = 1; b_valid = 1;
        @(posedge clk); #1;
        checks++;
        if ({b_ov, b_eq, b_gt, b_lt} !== 4'b1001) begin
            errors++;
            $display("FAIL w1_signed_1_0: got %b expected 1001", {b_ov, b_eq, b_gt, b_lt});
        end
        b_sm = 0;
        @(posedge clk); #1;
        checks++;
        if ({b_ov, b_eq, b_gt, b_lt} !== 4'b1010) begin
            errors++;
            $display("FAIL w1_unsigned_1_0: got %b expected 1010", {b_ov, b_eq, b_gt, b_lt});
        end
        b_valid = 0;
    endtask

    task automatic test_clr_priority();
        vec_t e;
        drive4(4'd2, 4'd5, 0, 1, 1);
        e = sb.pop_front();
        checks++;
        if (obs4() !== e || e !== 7'b1001_00_0) begin
            errors++;
            $display("FAIL clr_priority: got %b expected %b", obs4(), e);
        end
        drive4(4'd5, 4'd2, 0, 1, 0);
        e = sb.pop_front();
        checks++;
        if (obs4() !== e || a_cnt !== 2'd1) begin
            errors++;
            $display("FAIL after_clr_count: got %b expected %b", obs4(), e);
        end
    endtask

    task automatic test_saturation();
        vec_t e;
        drive4(4'd0, 4'd0, 0, 1, 1);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive4(4'(i), 4'(i + 1), 0, 1, 0);
            e = sb.pop_front();
            checks++;
            if (obs4() !== e) begin
                errors++;
                $display("FAIL saturation_%0d: got %b expected %b", i, obs4(), e);
            end
        end
        drive4(4'd7, 4'd7, 0, 1, 0);
        e = sb.pop_front();
        checks++;
        if (obs4() !== e || a_cnt !== 2'd3 || a_seen !== 1'b1) begin
            errors++;
            $display("FAIL sat_equal_hold: got %b expected %b", obs4(), e);
        end
    endtask

    task automatic test_back_to_back();
        vec_t e;
        logic [3:0] x, y;
        for (int i = 0; i < 40; i++) begin
            x = 4'($urandom_range(0, 15));
            y = ($urandom_range(0, 3) == 0) ? x : 4'($urandom_range(0, 15));
            a_x = x; a_y = y;
            #1;
            checks++;
            if (a_z !== (x == y)) begin
                errors++;
                $display("FAIL z_random x=%0d y=%0d: z=%b expected %b", x, y, a_z, (x == y));
            end
            drive4(x, y, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 7) == 0));
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at sample %0d", i);
            end else begin
                e = sb.pop_front();
                checks++;
                if (obs4() !== e) begin
                    errors++;
                    $display("FAIL back_to_back_%0d: got %b expected %b", i, obs4(), e);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        drive4(4'd3, 4'd12, 0, 1, 0);
        void'(sb.pop_front());
        #2;
        rst = 1;
        #1;
        checks++;
        if (obs4() !== 7'b0) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", obs4(), 7'b0);
        end
        a_x = 4'd6; a_y = 4'd6;
        #1;
        checks++;
        if (a_z !== 1'b1) begin
            errors++;
            $display("FAIL z_in_reset_eq: z=%b expected 1", a_z);
        end
        a_y = 4'd7;
        #1;
        checks++;
        if (a_z !== 1'b0) begin
            errors++;
            $display("FAIL z_in_reset_ne: z=%b expected 0", a_z);
        end
        a_valid = 0; a_clr = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
        drive4(4'd1, 4'd1, 0, 0, 0);
        checks++;
        if (obs4() !== sb.pop_front()) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 0", obs4());
        end
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_truth_table();
        @(negedge clk);
        rst = 0;
        test_unsigned();
        test_signed();
        test_clr_priority();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
